// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and size defaults for the DDR port arbiter.
package arb_pkg;
  typedef enum logic [2:0] {IDLE, F_REQ, F_BEAT0, F_BEAT1, L_REQ, L_WAIT} arb_state_e;
  localparam int IDX_W_DEF  = 19;
  localparam int DATA_W_DEF = 64;
  localparam int BEATS      = 2;
endpackage

// File: rtl/ddr_beat_collector.sv
// ddr_beat_collector: shifts fetch beats into a line and emits a registered done unless killed.
module ddr_beat_collector import arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      beat_valid,
  input  logic                      last,
  input  logic                      kill_in,
  input  logic [DATA_W-1:0]         data,
  output logic [BEATS*DATA_W-1:0]   line,
  output logic                      done
);
  logic kill;
  // Each beat enters at the top and pushes older beats down, so beat0 ends in the low word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line <= '0;
      kill <= 1'b0;
      done <= 1'b0;
    end else begin
      if (beat_valid) line <= {data, line[BEATS*DATA_W-1:DATA_W]};
      kill <= (beat_valid && last) ? 1'b0 : (kill || kill_in);
      done <= beat_valid && last && !(kill || kill_in);
    end
  end
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one DDR port between IFU burst fetches and LSU single-beat accesses.
// Define DDR_ARB_RR_EN for round-robin arbitration on simultaneous requests (default: LSU priority).
module ddr_port_arbiter import arb_pkg::*; #(
  parameter int IDX_W   = IDX_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FETCH_W = BEATS*DATA_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               redirect_valid,
  input  logic               pc_index_valid,
  input  logic [63:0]        pc_index,
  output logic               pc_index_ready,
  output logic               pc_operation_done,
  output logic [FETCH_W-1:0] pc_read_inst,
  input  logic               lsu_chip_enable,
  input  logic               lsu_write_enable,
  input  logic [IDX_W-1:0]   lsu_index,
  input  logic [DATA_W-1:0]  lsu_write_mask,
  input  logic [DATA_W-1:0]  lsu_write_data,
  output logic               lsu_ready,
  output logic               lsu_operation_done,
  output logic [DATA_W-1:0]  lsu_read_data,
  output logic               mem_stall,
  output logic               ddr_chip_enable,
  output logic               ddr_write_enable,
  output logic               ddr_burst_mode,
  output logic [IDX_W-1:0]   ddr_index,
  output logic [DATA_W-1:0]  ddr_write_mask,
  output logic [DATA_W-1:0]  ddr_write_data,
  input  logic               ddr_ready,
  input  logic               ddr_operation_done,
  input  logic [DATA_W-1:0]  ddr_read_data
);
  arb_state_e state, state_n;
  logic lsu_win, lsu_load, f_req_live, l_req, in_beat, unused_pc;
  assign unused_pc = ^{pc_index[63:IDX_W+3], pc_index[2:0]};
`ifdef DDR_ARB_RR_EN
  logic last_lsu;
  assign lsu_win = lsu_chip_enable && (!pc_index_valid || !last_lsu);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_lsu <= 1'b1;
    else if (state == IDLE && (lsu_chip_enable || pc_index_valid)) last_lsu <= lsu_win;
  end
`else
  assign lsu_win = lsu_chip_enable;
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = lsu_win ? L_REQ : pc_index_valid ? F_REQ : IDLE;
      F_REQ:   state_n = redirect_valid ? IDLE : ddr_ready ? F_BEAT0 : F_REQ;
      F_BEAT0: state_n = ddr_operation_done ? F_BEAT1 : F_BEAT0;
      F_BEAT1: state_n = ddr_operation_done ? IDLE : F_BEAT1;
      L_REQ:   state_n = ddr_ready ? L_WAIT : L_REQ;
      L_WAIT:  state_n = ddr_operation_done ? IDLE : L_WAIT;
      default: state_n = IDLE;
    endcase
  end
  // A redirect in F_REQ withdraws the request so no handshake can complete that cycle.
  assign f_req_live       = state == F_REQ && !redirect_valid;
  assign l_req            = state == L_REQ;
  assign in_beat          = state == F_BEAT0 || state == F_BEAT1;
  assign ddr_chip_enable  = f_req_live || l_req;
  assign ddr_burst_mode   = f_req_live;
  assign ddr_write_enable = l_req && lsu_write_enable;
  assign ddr_index        = f_req_live ? pc_index[IDX_W+2:3] : l_req ? lsu_index : '0;
  assign ddr_write_mask   = l_req ? lsu_write_mask : '0;
  assign ddr_write_data   = l_req ? lsu_write_data : '0;
  assign pc_index_ready   = f_req_live && ddr_ready;
  assign lsu_ready        = l_req && ddr_ready;
  assign mem_stall        = (state == IDLE && lsu_chip_enable) || l_req || state == L_WAIT || lsu_operation_done;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lsu_load           <= 1'b0;
      lsu_operation_done <= 1'b0;
      lsu_read_data      <= '0;
    end else begin
      if (lsu_ready) lsu_load <= !lsu_write_enable;
      lsu_operation_done <= state == L_WAIT && ddr_operation_done;
      if (state == L_WAIT && ddr_operation_done && lsu_load) lsu_read_data <= ddr_read_data;
    end
  end
  ddr_beat_collector #(.DATA_W(DATA_W)) u_collector (
    .clock      (clock),
    .reset_n    (reset_n),
    .beat_valid (in_beat && ddr_operation_done),
    .last       (state == F_BEAT1),
    .kill_in    (in_beat && redirect_valid),
    .data       (ddr_read_data),
    .line       (pc_read_inst),
    .done       (pc_operation_done)
  );
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed scoreboard bench; the initial block plays the IFU, LSU and DDR.
module tb_ddr_port_arbiter;
  localparam int IDX_W = 19, DATA_W = 64, FETCH_W = 128;
  logic clock = 1'b0, reset_n = 1'b0;
  logic redirect_valid = 0, pc_index_valid = 0, lsu_chip_enable = 0, lsu_write_enable = 0;
  logic ddr_ready = 0, ddr_operation_done = 0;
  logic [63:0] pc_index = '0;
  logic [IDX_W-1:0] lsu_index = '0, ddr_index;
  logic [DATA_W-1:0] lsu_write_mask = '0, lsu_write_data = '0, ddr_read_data = '0;
  logic [DATA_W-1:0] lsu_read_data, ddr_write_mask, ddr_write_data;
  logic [FETCH_W-1:0] pc_read_inst;
  logic pc_index_ready, pc_operation_done, lsu_ready, lsu_operation_done, mem_stall;
  logic ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
  int total = 0, bad = 0, fetch_dones = 0, lsu_dones = 0;
  logic [127:0] fetch_q[$];
  logic [63:0] lsu_q[$];
  logic [63:0] last_load = '0;
  logic [127:0] mon_f;
  logic [63:0] mon_l;

  always #5 clock = ~clock;

  ddr_port_arbiter dut (
    .clock(clock), .reset_n(reset_n), .redirect_valid(redirect_valid),
    .pc_index_valid(pc_index_valid), .pc_index(pc_index), .pc_index_ready(pc_index_ready),
    .pc_operation_done(pc_operation_done), .pc_read_inst(pc_read_inst),
    .lsu_chip_enable(lsu_chip_enable), .lsu_write_enable(lsu_write_enable), .lsu_index(lsu_index),
    .lsu_write_mask(lsu_write_mask), .lsu_write_data(lsu_write_data), .lsu_ready(lsu_ready),
    .lsu_operation_done(lsu_operation_done), .lsu_read_data(lsu_read_data), .mem_stall(mem_stall),
    .ddr_chip_enable(ddr_chip_enable), .ddr_write_enable(ddr_write_enable),
    .ddr_burst_mode(ddr_burst_mode), .ddr_index(ddr_index), .ddr_write_mask(ddr_write_mask),
    .ddr_write_data(ddr_write_data), .ddr_ready(ddr_ready),
    .ddr_operation_done(ddr_operation_done), .ddr_read_data(ddr_read_data)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion pulses pop the scoreboard; a pulse with nothing queued expects x and so fails.
  always @(negedge clock) begin
    if (reset_n && pc_operation_done === 1'b1) begin
      fetch_dones++;
      mon_f = fetch_q.size() != 0 ? fetch_q.pop_front() : 'x;
      total++;
      assert (pc_read_inst === mon_f) else begin
        bad++;
        $error("FAIL fetch_data observed=%0h expected=%0h", pc_read_inst, mon_f);
      end
    end
    if (reset_n && lsu_operation_done === 1'b1) begin
      lsu_dones++;
      mon_l = lsu_q.size() != 0 ? lsu_q.pop_front() : 'x;
      total++;
      assert (lsu_read_data === mon_l) else begin
        bad++;
        $error("FAIL lsu_data observed=%0h expected=%0h", lsu_read_data, mon_l);
      end
    end
  end

  task automatic fetch_rest(input logic [63:0] pc, input logic [63:0] b0, input logic [63:0] b1, input bit kill);
    chk("f_req_ce", ddr_chip_enable, 1);
    chk("f_req_burst", ddr_burst_mode, 1);
    chk("f_req_index", ddr_index, pc[IDX_W+2:3]);
    ddr_ready = 1; #1;
    chk("f_pc_ready", pc_index_ready, 1);
    @(negedge clock);
    ddr_ready = 0; pc_index_valid = 0;
    chk("f_beat_ce", ddr_chip_enable, 0);
    redirect_valid = kill;
    ddr_operation_done = 1; ddr_read_data = b0;
    if (!kill) fetch_q.push_back({b1, b0});
    @(negedge clock);
    redirect_valid = 0; ddr_read_data = b1;
    @(negedge clock);
    ddr_operation_done = 0;
    if (kill) chk("f_killed_done", pc_operation_done, 0);
  endtask

  task automatic do_fetch(input logic [63:0] pc, input logic [63:0] b0, input logic [63:0] b1, input bit kill);
    pc_index_valid = 1; pc_index = pc;
    @(negedge clock);
    fetch_rest(pc, b0, b1, kill);
  endtask

  task automatic lsu_rest(input bit we, input logic [IDX_W-1:0] idx, input logic [63:0] mask,
                          input logic [63:0] data, input logic [63:0] rdata);
    chk("l_req_ce", ddr_chip_enable, 1);
    chk("l_req_we", ddr_write_enable, we);
    chk("l_req_burst", ddr_burst_mode, 0);
    chk("l_req_index", ddr_index, idx);
    chk("l_req_mask", ddr_write_mask, mask);
    chk("l_req_data", ddr_write_data, data);
    chk("l_req_stall", mem_stall, 1);
    ddr_ready = 1; #1;
    chk("l_ready", lsu_ready, 1);
    chk("l_no_pc_ready", pc_index_ready, 0);
    @(negedge clock);
    ddr_ready = 0; lsu_chip_enable = 0;
    chk("l_wait_ce", ddr_chip_enable, 0);
    chk("l_wait_stall", mem_stall, 1);
    ddr_operation_done = 1; ddr_read_data = rdata;
    if (!we) last_load = rdata;
    lsu_q.push_back(last_load);
    @(negedge clock);
    ddr_operation_done = 0;
    chk("l_done_stall", mem_stall, 1);
    @(negedge clock);
    chk("l_after_stall", mem_stall, 0);
  endtask

  task automatic do_lsu(input bit we, input logic [IDX_W-1:0] idx, input logic [63:0] mask,
                        input logic [63:0] data, input logic [63:0] rdata);
    lsu_chip_enable = 1; lsu_write_enable = we; lsu_index = idx;
    lsu_write_mask = mask; lsu_write_data = data; #1;
    chk("l_idle_stall", mem_stall, 1);
    @(negedge clock);
    lsu_rest(we, idx, mask, data, rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_ce", ddr_chip_enable, 0);
    chk("rst_inst", pc_read_inst, 0);
    chk("rst_lsu_data", lsu_read_data, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_pc_done", pc_operation_done, 0);
    reset_n = 1;
    @(negedge clock);
    do_fetch(64'h8000_0010, 64'hA, 64'hB, 0);
    chk("f1_index_val", ddr_index, 0);
    do_lsu(1, 19'h40, '1, 64'h55, 64'hBAD0_BAD0);
    do_lsu(0, 19'h41, '0, '0, 64'h1122_3344_5566_7788);
    pc_index_valid = 1; pc_index = 64'h100;
    lsu_chip_enable = 1; lsu_write_enable = 1; lsu_index = 19'h77;
    lsu_write_mask = '1; lsu_write_data = 64'h99;
    @(negedge clock);
`ifdef DDR_ARB_RR_EN
    chk("tie_fetch_first", ddr_burst_mode, 1);
    fetch_rest(64'h100, 64'hC0, 64'hC1, 0);
    @(negedge clock);
    lsu_rest(1, 19'h77, '1, 64'h99, 64'h0);
`else
    chk("tie_lsu_first", ddr_burst_mode, 0);
    lsu_rest(1, 19'h77, '1, 64'h99, 64'h0);
    fetch_rest(64'h100, 64'hC0, 64'hC1, 0);
`endif
    lsu_chip_enable = 1; lsu_write_enable = 0; lsu_index = 19'h1ABCD;
    lsu_write_mask = 64'hFF00; lsu_write_data = 64'h1234;
    @(negedge clock);
    pc_index_valid = 1; pc_index = 64'h40;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_ce", ddr_chip_enable, 1);
      chk("stall_index", ddr_index, 19'h1ABCD);
      chk("stall_pc_ready", pc_index_ready, 0);
      @(negedge clock);
    end
    pc_index_valid = 0;
    lsu_rest(0, 19'h1ABCD, 64'hFF00, 64'h1234, 64'hCAFE_F00D);
    pc_index_valid = 1; pc_index = 64'h300;
    @(negedge clock);
    redirect_valid = 1; ddr_ready = 1; #1;
    chk("freq_redir_ready", pc_index_ready, 0);
    chk("freq_redir_ce", ddr_chip_enable, 0);
    @(negedge clock);
    redirect_valid = 0; ddr_ready = 0; pc_index_valid = 0;
    chk("freq_redir_idle", ddr_chip_enable, 0);
    @(negedge clock);
    chk("freq_redir_stay", ddr_chip_enable, 0);
    redirect_valid = 1; pc_index_valid = 1; pc_index = 64'h8000_0018;
    @(negedge clock);
    redirect_valid = 0; #1;
    fetch_rest(64'h8000_0018, 64'h11, 64'h22, 0);
    do_fetch(64'h500, 64'hDEAD, 64'hBEEF, 1);
    do_fetch(64'h508, 64'h33, 64'h44, 0);
    pc_index_valid = 1; pc_index = 64'h2000;
    @(negedge clock);
    ddr_ready = 1;
    @(negedge clock);
    ddr_ready = 0; pc_index_valid = 0; ddr_operation_done = 1; ddr_read_data = 64'hFEED;
    @(negedge clock);
    ddr_operation_done = 0;
    #2 reset_n = 0; #1;
    last_load = '0;
    chk("arst_inst", pc_read_inst, 0);
    chk("arst_ce", ddr_chip_enable, 0);
    chk("arst_lsu_data", lsu_read_data, 0);
    chk("arst_stall", mem_stall, 0);
    @(negedge clock);
    chk("arst_pc_done", pc_operation_done, 0);
    reset_n = 1;
    @(negedge clock);
    do_fetch(64'h8000_0020, 64'h77, 64'h88, 0);
    @(negedge clock);
    chk("fetch_dones", fetch_dones, 5);
    chk("lsu_dones", lsu_dones, 4);
    chk("fetch_q_empty", fetch_q.size(), 0);
    chk("lsu_q_empty", lsu_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
